// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
package adder_rr_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } occ_state_t;

    localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester strictly after last_grant, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic            any_valid,
    output logic [IDW-1:0]  grant
);

    int idx;

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Time-shares one WIDTH-bit adder among NREQ requesters with round-robin grant
// and a one-entry result register on a valid/ready output.
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id,
    output logic [7:0]            ovf_cnt
);

    occ_state_t       state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             can_accept;
    logic             req_fire;
    logic             rsp_fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_full;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req       (req_valid),
        .last_grant(last_grant),
        .any_valid (any_valid),
        .grant     (grant)
    );

    // A full register can still take a new result when it is drained the same cycle.
    assign rsp_valid  = (state == ST_FULL);
    assign can_accept = (state == ST_EMPTY) || rsp_ready;
    assign req_fire   = any_valid && can_accept;
    assign rsp_fire   = rsp_valid && rsp_ready;

    assign op_a     = req_a[int'(grant)*WIDTH +: WIDTH];
    assign op_b     = req_b[int'(grant)*WIDTH +: WIDTH];
    assign sum_full = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        req_ready = '0;
        if (req_fire) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= '0;
            ovf_cnt    <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            if (rsp_fire && rsp_carry && (ovf_cnt != OVF_CNT_MAX)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (req_fire) begin
                {rsp_carry, rsp_sum} <= sum_full;
                rsp_id     <= grant;
                last_grant <= grant;
                state      <= ST_FULL;
            end else if (rsp_fire) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: a queue-free reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_adder_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;
    logic [7:0]            ovf_cnt;

    int n_compared;
    int n_mismatched;

    // Reference model: what the result register and counter must hold after each edge.
    bit m_full;
    int m_sum;
    int m_carry;
    int m_id;
    int m_ptr;
    int m_ovf;
    int grant_log[$];

    adder_rr_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_carry(rsp_carry),
        .rsp_id   (rsp_id),
        .ovf_cnt  (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // First valid requester after the pointer, wrapping; -1 when nobody asks.
    function automatic int pickNext(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Mid-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        int g;
        int exp_ready;
        int s;
        bit can;
        bit rsp_hs;
        if (!rst_n) begin
            m_full  = 1'b0;
            m_sum   = 0;
            m_carry = 0;
            m_id    = 0;
            m_ptr   = NREQ - 1;
            m_ovf   = 0;
            checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
            checkOutput("rst_ovf_cnt", int'(ovf_cnt), 0);
        end else begin
            g         = pickNext(m_ptr, req_valid);
            can       = !m_full || rsp_ready;
            exp_ready = (g >= 0 && can) ? (1 << g) : 0;
            checkOutput("mdl_req_ready", int'(req_ready), exp_ready);
            checkOutput("mdl_rsp_valid", int'(rsp_valid), int'(m_full));
            checkOutput("mdl_ovf_cnt", int'(ovf_cnt), m_ovf);
            if (m_full) begin
                checkOutput("mdl_rsp_sum", int'(rsp_sum), m_sum);
                checkOutput("mdl_rsp_carry", int'(rsp_carry), m_carry);
                checkOutput("mdl_rsp_id", int'(rsp_id), m_id);
            end
            rsp_hs = m_full && rsp_ready;
            if (rsp_hs && m_carry == 1 && m_ovf < 255) m_ovf++;
            if (g >= 0 && can) begin
                s       = int'(req_a[g*WIDTH +: WIDTH]) + int'(req_b[g*WIDTH +: WIDTH]);
                m_sum   = s % (1 << WIDTH);
                m_carry = s / (1 << WIDTH);
                m_id    = g;
                m_ptr   = g;
                m_full  = 1'b1;
                grant_log.push_back(g);
            end else if (rsp_hs) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr, input int n);
        req_valid = v;
        rsp_ready = rr;
        stepCycles(n);
    endtask

    task automatic setOperands(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        stepCycles(1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        req_valid    = '0;
        rsp_ready    = 1'b0;
        req_a        = '0;
        req_b        = '0;
        stepCycles(2);
        rst_n = 1'b1;

        // Single request from requester 0.
        setOperands(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checkOutput("t1_req_ready", int'(req_ready), 1);
        stepCycles(1);
        checkOutput("t1_rsp_valid", int'(rsp_valid), 1);
        checkOutput("t1_rsp_sum", int'(rsp_sum), 'h46);
        checkOutput("t1_rsp_carry", int'(rsp_carry), 0);
        checkOutput("t1_rsp_id", int'(rsp_id), 0);
        applyStimulus(4'b0000, 1'b1, 2);

        // All four requesters streaming from a fresh pointer.
        pulseReset();
        for (int i = 0; i < NREQ; i++) setOperands(i, 8'(16 * i + 1), 8'(i + 2));
        grant_log.delete();
        applyStimulus(4'b1111, 1'b1, 5);
        checkOutput("t2_n_grants", grant_log.size(), 5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) checkOutput("t2_grant_order", grant_log[i], i % NREQ);
        end
        checkOutput("t2_rsp_id", int'(rsp_id), 0);
        checkOutput("t2_rsp_sum", int'(rsp_sum), 3);
        applyStimulus(4'b0000, 1'b1, 2);

        // Backpressure with requesters 1 and 2 waiting behind a pending result.
        applyStimulus(4'b1000, 1'b0, 1);
        req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("t3_ready_blocked", int'(req_ready), 0);
            checkOutput("t3_hold_id", int'(rsp_id), 3);
            checkOutput("t3_hold_sum", int'(rsp_sum), 'h36);
            stepCycles(1);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("t3_ready_release", int'(req_ready), 4'b0010);
        stepCycles(1);
        checkOutput("t3_rsp_valid", int'(rsp_valid), 1);
        checkOutput("t3_rsp_id", int'(rsp_id), 1);
        checkOutput("t3_rsp_sum", int'(rsp_sum), 'h14);
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("t3_drained", int'(rsp_valid), 0);

        // Carry results and counter saturation.
        setOperands(0, 8'hFF, 8'h01);
        applyStimulus(4'b0001, 1'b1, 1);
        checkOutput("t4_rsp_sum", int'(rsp_sum), 0);
        checkOutput("t4_rsp_carry", int'(rsp_carry), 1);
        checkOutput("t4_ovf_before", int'(ovf_cnt), 0);
        stepCycles(1);
        checkOutput("t4_ovf_first", int'(ovf_cnt), 1);
        stepCycles(300);
        checkOutput("t4_ovf_saturated", int'(ovf_cnt), 255);
        applyStimulus(4'b0000, 1'b1, 2);
        checkOutput("t4_ovf_held", int'(ovf_cnt), 255);

        // Pointer after granting 2 makes requester 0 win over 2.
        applyStimulus(4'b0100, 1'b1, 1);
        grant_log.delete();
        applyStimulus(4'b0101, 1'b1, 2);
        checkOutput("t5_n_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            checkOutput("t5_first", grant_log[0], 0);
            checkOutput("t5_second", grant_log[1], 2);
        end
        applyStimulus(4'b0000, 1'b1, 2);

        // Asynchronous reset while a result is pending.
        applyStimulus(4'b0010, 1'b0, 1);
        checkOutput("t6_pending", int'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", int'(rsp_valid), 0);
        checkOutput("t6_async_ovf", int'(ovf_cnt), 0);
        checkOutput("t6_async_sum", int'(rsp_sum), 0);
        stepCycles(1);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checkOutput("t6_priority", int'(req_ready), 4'b0001);
        applyStimulus(4'b0000, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares a single WIDTH-bit adder between NREQ requesters using round-robin arbitration and valid/ready handshakes on both sides. Each request carries two operands. The granted pair is summed and the sum, carry and requester ID are held in a one-entry output register until consumed. The block sits between the project's input decode logic and the output mux, so several producers can time-share one adder datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand and sum width in bits
IDW, $clog2(NREQ), requester ID width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing as req_a
rsp_valid  out  1  result register holds a valid result
rsp_ready  in  1  consumer accepts result
rsp_sum  out  WIDTH  registered sum, low WIDTH bits of a+b
rsp_carry  out  1  registered carry-out, bit WIDTH of a+b
rsp_id  out  IDW  index of the requester that produced the result
ovf_cnt  out  8  saturating count of accepted results with carry=1

Behaviour:
- Reset (asynchronous, rst_n=0): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, ovf_cnt=0, last_grant=NREQ-1. After reset, requester 0 has top priority. A pending result is discarded.
- Two-state occupancy FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY, or (FULL and rsp_ready).
- Arbitration is combinational. Search starts at (last_grant+1) mod NREQ and wraps upward. The first i with req_valid[i]=1 is the grant g.
- req_ready[g]=can_accept. All other req_ready bits are 0. When no requester is valid or can_accept=0, req_ready is all zero.
- A request handshake occurs when req_valid[g] and req_ready[g] are both 1. On that clock edge:
  - {rsp_carry,rsp_sum} <= zero-extended a+b, computed in WIDTH+1 bits.
  - rsp_id <= g, last_grant <= g, state <= FULL.
- Response: a handshake occurs when rsp_valid and rsp_ready are both 1. If no new request is accepted in the same cycle, state <= EMPTY. rsp_sum, rsp_carry and rsp_id keep their old values, but are don't-care while rsp_valid=0.
- Simultaneous response and request handshakes: the register reloads with the new result and rsp_valid stays 1. This gives full throughput of one result per cycle.
- Stability: while FULL and rsp_ready=0, rsp_sum, rsp_carry and rsp_id must not change.
- ovf_cnt increments on each response handshake where rsp_carry=1. It saturates at 255 and does not wrap.
- Latency: request accept to rsp_valid=1 is 1 cycle.
- Fairness: a continuously asserted requester is granted within NREQ accepts.
- last_grant updates only on a request handshake. A req_valid that drops without being accepted does not move the pointer.
- req_valid/operand changes while not accepted: the block holds no state for them. The requester is responsible for holding its data until accepted.

Decomposition:
- Shared package holds:
  - the FSM state enum (ST_EMPTY, ST_FULL)
  - the ovf_cnt saturation constant (8'hFF)
  - a localparam helper for IDW
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: req vector and last_grant.
  - Outputs: any_valid and grant index.
- The adder, output register, FSM and counter stay in the top block.

Test Plan:
1. Reset, then req_valid=4'b0001 with a=8'h12, b=8'h34, rsp_ready=1 -> req_ready=4'b0001. Next cycle: rsp_valid=1, rsp_sum=8'h46, rsp_carry=0, rsp_id=0.
2. All four valid continuously, rsp_ready=1, distinct operands -> grants in order 0,1,2,3,0. One result per cycle with no bubbles, and each rsp_id matches its operands.
3. Backpressure: result pending with rsp_ready=0 for 5 cycles while req_valid=4'b0110 -> req_ready=0 and outputs held stable. On rsp_ready=1, requester 1 is accepted in the same cycle and rsp_valid stays 1.
4. Carry: a=8'hFF, b=8'h01 -> rsp_sum=8'h00, rsp_carry=1, ovf_cnt 0->1 on the response handshake. After 300 such results, ovf_cnt=255.
5. Pointer hold: grant requester 2, then req_valid=4'b0101 -> requester 0 is granted (search starts at 3, wraps to 0), then requester 2.
6. Reset mid-operation: rst_n=0 asserted asynchronously while rsp_valid=1 -> rsp_valid=0 and ovf_cnt=0 immediately, without a clock edge. After release, requester 0 has priority.
